// File: rtl/tone_synth_r2r.sv
// Multi-voice sine tone generator for the R2R DAC: per-voice phase accumulator
// and sine ROM, one-entry staged config port, solo/mix output stage.

module tone_synth_voice #(
    parameter int DAC_W      = 7,
    parameter int PHASE_W    = 16,
    parameter int LUT_ADDR_W = 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               ld,
    input  logic [PHASE_W-1:0] ld_ftw,
    input  logic               ld_gate,
    output logic [DAC_W-1:0]   samp
);
    localparam int  LUT_N = 1 << LUT_ADDR_W;
    localparam int  MID   = 1 << (DAC_W - 1);
    localparam real PI    = 3.14159265358979323846;

    // Elaboration-time sine: fold into the first quadrant, then Taylor series.
    function automatic int lut_val(input int a);
        real x, term, s, v;
        bit  neg;
        x   = 2.0 * PI * $itor(a) / $itor(LUT_N);
        neg = 1'b0;
        if (x > PI) begin
            x   = x - PI;
            neg = 1'b1;
        end
        if (x > PI / 2.0) x = PI - x;
        term = x;
        s    = x;
        for (int k = 1; k <= 10; k++) begin
            term = -term * x * x / $itor((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        v = $itor(MID - 1) * s;
        if (neg) v = -v;
        return (v >= 0.0) ? MID + $rtoi(v + 0.5) : MID - $rtoi(0.5 - v);
    endfunction

    logic [DAC_W-1:0] rom [LUT_N];
    for (genvar a = 0; a < LUT_N; a++) begin : g_rom
        localparam int LV = lut_val(a);
        assign rom[a] = LV[DAC_W-1:0];
    end

    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               gate_q, gate_d;
    logic [DAC_W-1:0]   samp_q, samp_d;

    // Staged config lands first so the same tick already advances with it.
    always_comb begin
        ftw_d   = ftw_q;
        gate_d  = gate_q;
        phase_d = phase_q;
        samp_d  = samp_q;
        if (tick) begin
            if (ld) begin
                ftw_d  = ld_ftw;
                gate_d = ld_gate;
            end
            phase_d = gate_d ? phase_q + ftw_d : '0;
            samp_d  = gate_d ? rom[phase_d[PHASE_W-1 -: LUT_ADDR_W]] - DAC_W'(MID) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ftw_q   <= '0;
            gate_q  <= 1'b0;
            phase_q <= '0;
            samp_q  <= '0;
        end else begin
            ftw_q   <= ftw_d;
            gate_q  <= gate_d;
            phase_q <= phase_d;
            samp_q  <= samp_d;
        end
    end

    assign samp = samp_q;
endmodule

module tone_synth_r2r #(
    parameter int   NUM_VOICES = 4,
    parameter int   DAC_W      = 7,
    parameter int   PHASE_W    = 16,
    parameter int   LUT_ADDR_W = 6,
    parameter int   TICK_DIV   = 1000,
    localparam int  VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [VW-1:0]      cfg_voice,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic               cfg_gate,
    input  logic               mode,
    input  logic [VW-1:0]      solo_sel,
    output logic               sample_tick,
    output logic [DAC_W-1:0]   r2r
);
    localparam int               CW  = $clog2(TICK_DIV);
    localparam int               SH  = $clog2(NUM_VOICES);
    localparam int               SW  = DAC_W + SH + 1;
    localparam logic [DAC_W-1:0] MID = DAC_W'(1 << (DAC_W - 1));

    typedef struct packed {
        logic [VW-1:0]      voice;
        logic [PHASE_W-1:0] ftw;
        logic               gate;
    } cfg_t;

    logic [CW-1:0]                    cnt_q, cnt_d;
    cfg_t                             stg_q, stg_d;
    logic                             stg_vld_q, stg_vld_d;
    logic                             samp_vld_q, samp_vld_d;
    logic [DAC_W-1:0]                 r2r_q, r2r_d;
    logic                             tick;
    logic [NUM_VOICES-1:0]            ld;
    logic [NUM_VOICES-1:0][DAC_W-1:0] samp;
    logic signed [SW-1:0]             mix_sum;
    logic [DAC_W-1:0]                 mix_shf;
    logic [DAC_W-1:0]                 solo_s;

    assign tick        = !en_n && (cnt_q == CW'(TICK_DIV - 1));
    assign sample_tick = tick;
    assign cfg_ready   = !stg_vld_q;
    assign r2r         = r2r_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_n) cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Ready is simply "staging empty": it drops after capture and returns
    // the cycle after the tick that consumes the entry.
    always_comb begin
        stg_d     = stg_q;
        stg_vld_d = stg_vld_q;
        if (tick) stg_vld_d = 1'b0;
        if (cfg_valid && cfg_ready) begin
            stg_vld_d   = 1'b1;
            stg_d.voice = cfg_voice;
            stg_d.ftw   = cfg_ftw;
            stg_d.gate  = cfg_gate;
        end
    end

    // Out-of-range voice indices match no lane and are dropped on apply.
    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign ld[i] = stg_vld_q && (stg_q.voice == VW'(i));
        tone_synth_voice #(
            .DAC_W      (DAC_W),
            .PHASE_W    (PHASE_W),
            .LUT_ADDR_W (LUT_ADDR_W)
        ) u_voice (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .ld      (ld[i]),
            .ld_ftw  (stg_q.ftw),
            .ld_gate (stg_q.gate),
            .samp    (samp[i])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_VOICES; i++) mix_sum = mix_sum + SW'($signed(samp[i]));
        mix_shf = DAC_W'(mix_sum >>> SH);
        solo_s  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (solo_sel == VW'(i)) solo_s = samp[i];
        end
        samp_vld_d = en_n ? samp_vld_q : tick;
        r2r_d      = r2r_q;
        if (samp_vld_q && !en_n) r2r_d = MID + (mode ? mix_shf : solo_s);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            stg_q      <= '0;
            stg_vld_q  <= 1'b0;
            samp_vld_q <= 1'b0;
            r2r_q      <= MID;
        end else begin
            cnt_q      <= cnt_d;
            stg_q      <= stg_d;
            stg_vld_q  <= stg_vld_d;
            samp_vld_q <= samp_vld_d;
            r2r_q      <= r2r_d;
        end
    end
endmodule

// File: tb/tb_tone_synth_r2r.sv
// Bench for tone_synth_r2r: cycle model feeds an r2r scoreboard for a 4-voice
// and a 3-voice instance sharing the same stimulus.
module tb_tone_synth_r2r;
    localparam int TD  = 8;
    localparam int MID = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en_n = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_gate = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  cfg_voice = '0;
    logic [1:0]  solo_sel = '0;
    logic [15:0] cfg_ftw = '0;
    logic        rdy4, rdy3, tk4, tk3;
    logic [6:0]  r2r4, r2r3;

    always #5 clk = ~clk;

    tone_synth_r2r #(.NUM_VOICES(4), .DAC_W(7), .PHASE_W(16), .LUT_ADDR_W(6), .TICK_DIV(TD)) u_dut (
        .clk(clk), .reset_n(reset_n), .en_n(en_n), .cfg_valid(cfg_valid), .cfg_ready(rdy4),
        .cfg_voice(cfg_voice), .cfg_ftw(cfg_ftw), .cfg_gate(cfg_gate), .mode(mode),
        .solo_sel(solo_sel), .sample_tick(tk4), .r2r(r2r4));

    tone_synth_r2r #(.NUM_VOICES(3), .DAC_W(7), .PHASE_W(16), .LUT_ADDR_W(6), .TICK_DIV(TD)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .en_n(en_n), .cfg_valid(cfg_valid), .cfg_ready(rdy3),
        .cfg_voice(cfg_voice), .cfg_ftw(cfg_ftw), .cfg_gate(cfg_gate), .mode(mode),
        .solo_sel(solo_sel), .sample_tick(tk3), .r2r(r2r3));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cnt;
    bit          m_stg_vld, m_stg_gate, m_pend;
    int          m_stg_voice;
    logic [15:0] m_stg_ftw;
    logic [15:0] m_phase [2][4];
    logic [15:0] m_ftw   [2][4];
    bit          m_gate  [2][4];
    int          m_r2r   [2];
    int          exp_q0[$];
    int          exp_q1[$];

    function automatic int nv(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int lut_ref(input int a);
        real v;
        v = 63.0 * $sin(2.0 * 3.14159265358979 * $itor(a) / 64.0);
        return (v >= 0.0) ? MID + $rtoi(v + 0.5) : MID - $rtoi(0.5 - v);
    endfunction

    function automatic int voice_s(input int d, input int v);
        if (!m_gate[d][v]) return 0;
        return lut_ref(int'(m_phase[d][v][15:10])) - MID;
    endfunction

    function automatic int out_ref(input int d);
        int s = 0;
        if (mode) begin
            for (int v = 0; v < nv(d); v++) s += voice_s(d, v);
            return MID + (s >>> $clog2(nv(d)));
        end
        if (int'(solo_sel) < nv(d)) return MID + voice_s(d, int'(solo_sel));
        return MID;
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_stg_vld = 0; m_stg_gate = 0; m_pend = 0; m_stg_voice = 0; m_stg_ftw = '0;
        for (int d = 0; d < 2; d++) begin
            m_r2r[d] = MID;
            for (int v = 0; v < 4; v++) begin
                m_phase[d][v] = '0; m_ftw[d][v] = '0; m_gate[d][v] = 0;
            end
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic m_step();
        bit tk, acc;
        int e;
        tk  = !en_n && (m_cnt == TD - 1);
        acc = cfg_valid && !m_stg_vld;
        if (!en_n && m_pend) begin
            for (int d = 0; d < 2; d++) begin
                e = out_ref(d);
                m_r2r[d] = e;
                if (d == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
            end
            m_pend = 0;
        end
        if (tk) begin
            for (int d = 0; d < 2; d++) begin
                for (int v = 0; v < nv(d); v++) begin
                    if (m_stg_vld && m_stg_voice == v) begin
                        m_ftw[d][v]  = m_stg_ftw;
                        m_gate[d][v] = m_stg_gate;
                    end
                    m_phase[d][v] = m_gate[d][v] ? m_phase[d][v] + m_ftw[d][v] : 16'd0;
                end
            end
            m_stg_vld = 0;
            m_pend    = 1;
        end
        if (acc) begin
            m_stg_vld = 1; m_stg_voice = int'(cfg_voice); m_stg_ftw = cfg_ftw; m_stg_gate = cfg_gate;
        end
        if (!en_n) m_cnt = tk ? 0 : m_cnt + 1;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) m_reset();
            else          m_step();
        end
    end

    // ---------------- per-cycle checker / scoreboard ----------------
    initial begin
        bit e_tick;
        forever begin
            @(negedge clk);
            e_tick = reset_n && !en_n && (m_cnt == TD - 1);
            chk("tick4", tk4, e_tick);
            chk("tick3", tk3, e_tick);
            chk("ready4", rdy4, !m_stg_vld);
            chk("ready3", rdy3, !m_stg_vld);
            if (exp_q0.size() > 0) chk("r2r_upd4", r2r4, exp_q0.pop_front());
            else                   chk("r2r_hold4", r2r4, m_r2r[0]);
            if (exp_q1.size() > 0) chk("r2r_upd3", r2r3, exp_q1.pop_front());
            else                   chk("r2r_hold3", r2r3, m_r2r[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cfg(input int v, input int f, input bit g);
        bit ok = 0;
        @(posedge clk); #1;
        cfg_valid = 1'b1; cfg_voice = v[1:0]; cfg_ftw = f[15:0]; cfg_gate = g;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rdy4) ok = 1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end else chk("cfg_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic send_on_tick(input int v, input int f, input bit g);
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (tk4 && rdy4) ok = 1;
        end
        if (!ok) chk("tick_cfg_timeout", 0, 1);
        cfg_valid = 1'b1; cfg_voice = v[1:0]; cfg_ftw = f[15:0]; cfg_gate = g;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int i = 0; i < n * TD * 3 + 20 && seen < n; i++) begin
            @(negedge clk);
            if (tk4) seen++;
        end
        if (seen < n) chk("tick_timeout", seen, n);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic seq_check(input string tag, input int n, input int v0, input int v1,
                             input int v2, input int v3, input int v4);
        int vals[5];
        bit ok;
        vals = '{v0, v1, v2, v3, v4};
        for (int k = 0; k < n; k++) begin
            ok = 0;
            for (int i = 0; i < 4 * TD && !ok; i++) begin
                @(negedge clk);
                if (tk4) ok = 1;
            end
            if (!ok) chk({tag, "_timeout"}, 0, 1);
            @(negedge clk);
            @(negedge clk);
            chk(tag, r2r4, vals[k]);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r2r", r2r4, MID);
        chk("rst_ready", rdy4, 1);
        reset_n = 1'b1;
        en_n    = 1'b0;

        // single voice quarter-wave stepping in solo mode
        send_cfg(0, 16384, 1);
        seq_check("solo_seq", 5, 127, 64, 1, 64, 127);

        // run enable held off: no ticks, output frozen, count resumes
        en_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        en_n = 1'b0;
        wait_ticks(3);

        // async reset mid-run while output is away from midscale
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (r2r4 != 7'(MID)) seen = 1;
        end
        chk("pre_reset_nonmid", seen, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_r2r4", r2r4, MID);
        chk("async_rst_r2r3", r2r3, MID);
        chk("async_rst_ready", rdy4, 1);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        wait_ticks(2);

        // mix: align voices 0 and 1 on the same phase, then ungate voice 1
        mode = 1'b1;
        send_cfg(1, 16384, 1);
        send_cfg(0, 32768, 1);
        send_cfg(0, 16384, 1);
        seq_check("mix_seq", 4, 32, 64, 95, 64, 0);
        send_cfg(1, 16384, 0);
        wait_ticks(5);

        // back-to-back offers, tick-aligned accept, out-of-range voice on 3-voice DUT
        mode     = 1'b0;
        solo_sel = 2'd3;
        send_cfg(2, 1000, 1);
        chk("pend_ready_low", rdy4, 0);
        send_on_tick(3, 16384, 1);
        wait_ticks(4);
        chk("oor_solo3", r2r3, MID);
        solo_sel = 2'd1;
        wait_ticks(2);
        chk("ungated_solo4", r2r4, MID);
        chk("ungated_solo3", r2r3, MID);
        solo_sel = 2'd3;
        wait_ticks(3);

        // random configs, modes and selections
        for (int r = 0; r < 8; r++) begin
            send_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                     bit'($urandom_range(0, 1)));
            mode     = 1'($urandom_range(0, 1));
            solo_sel = 2'($urandom_range(0, 3));
            wait_ticks(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        chk("watchdog", 0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
